softmax_arbiter: RTL and testbench
==================================

Name: softmax_arbiter

Overview:
Frame-granular round-robin arbiter that shares one softmax datapath between two requester channels.
- Each channel supplies vectors of VEC_LEN values through its own input FIFO and receives results through its own output FIFO.
- The arbiter grants one channel for a whole frame. It steers that channel's input FIFO into the softmax read port, then routes all VEC_LEN softmax results to that channel's output FIFO before releasing the grant.
- It sits between the channel FIFOs and the softmax instance, replacing the direct fifo_in/fifo_out connections.

Parameters:
DWIDTH_IN, 16, input sample width (matches softmax DWIDTH_IN)
DWIDTH_OUT, 16, result width (matches softmax DWIDTH_OUT)
VEC_LEN, 100, values per softmax frame; legal range is 2 and up
CNT_W, $clog2(VEC_LEN+1), derived counter width; not to be overridden

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in0_rd_en  out  1  read strobe to channel-0 input FIFO
in0_dout  in  DWIDTH_IN  channel-0 input FIFO data (first-word-fall-through: valid while !in0_empty)
in0_empty  in  1  channel-0 input FIFO empty
in1_rd_en / in1_dout / in1_empty  same as channel 0, for channel 1
sm_rd_en  in  1  softmax fifo_in_rd_en
sm_dout  out  DWIDTH_IN  drives softmax fifo_in_dout
sm_empty  out  1  drives softmax fifo_in_empty
sm_wr_en  in  1  softmax fifo_out_wr_en
sm_din  in  DWIDTH_OUT  softmax fifo_out_din
sm_full  out  1  drives softmax fifo_out_full
out0_wr_en  out  1  write strobe to channel-0 output FIFO
out0_din  out  DWIDTH_OUT  data to channel-0 output FIFO
out0_full  in  1  channel-0 output FIFO full
out1_wr_en / out1_din / out1_full  same as channel 0, for channel 1
grant  out  1  channel currently owning the softmax (valid when busy)
busy  out  1  a frame is in progress
frame_done  out  1  one-cycle pulse when a frame's last result is written
err  out  1  sticky flag: softmax write with no owning frame, or excess write

Behaviour:
Reset values:
- state=IDLE, grant=0, last_grant=1 (channel 0 wins first), in_cnt=0, out_cnt=0.
- busy=0, frame_done=0, err=0.
- All rd_en/wr_en outputs are 0; sm_empty=1 and sm_full=1.

State machine: IDLE, FEED, DRAIN (encoded as 2 bits).
- IDLE:
  - Candidates are the channels whose input FIFO is not empty.
  - If both are candidates, grant the channel != last_grant. If exactly one, grant it.
  - The grant is registered and the state goes to FEED on the next edge; no data moves during the IDLE cycle.
- FEED:
  - sm_empty = inG_empty; sm_dout = inG_dout; inG_rd_en = sm_rd_en & !inG_empty.
  - The other channel's rd_en is held at 0.
  - Each accepted read increments in_cnt. The read that makes in_cnt == VEC_LEN moves the state to DRAIN.
- DRAIN:
  - sm_empty = 1 and sm_dout = 0, so the softmax sees no further input.
- Output routing, in both FEED and DRAIN:
  - sm_full = outG_full; outG_din = sm_din; outG_wr_en = sm_wr_en & !outG_full.
  - The other channel's wr_en stays 0.
  - Each accepted write increments out_cnt. Results may legally start during FEED.
- Frame completion:
  - The write that makes out_cnt == VEC_LEN pulses frame_done in the following cycle.
  - On that same edge: last_grant <= grant, both counters clear, state goes to IDLE.
  - There is a minimum one IDLE cycle between frames.
- busy = (state != IDLE).
- Error cases, all setting err:
  - sm_wr_en asserted in IDLE. sm_full is 1 there, so the write is dropped.
  - A write after out_cnt == VEC_LEN.
  - sm_rd_en with sm_empty=1 is not an error; it is ignored.
- Input empty mid-frame: FEED holds and waits; the grant is never revoked mid-frame.
- Output full: backpressure passes straight through to the softmax via sm_full; counts advance only on accepted writes.
- Reset mid-frame: returns to IDLE and abandons the partial frame. The softmax shares this reset and discards its state too.
- All muxing is combinational on the registered grant and state; zero added latency on the data paths.

Decomposition:
- Package softmax_arb_pkg:
  - state type (IDLE/FEED/DRAIN)
  - channel index constants CH0/CH1
  - clog2 helper for CNT_W
- One natural sub-module: rr_pick2. Combinational two-way round-robin select taking req[1:0] and last and returning gnt and valid. It is reusable if the channel count grows.
- Counters, FSM and steering muxes stay in the top module.

Test Plan:
- Only channel 0 loaded with 100 values, softmax stub returns 100 results:
  - grant=0 throughout
  - out0 receives 100 words; out1_wr_en is never 1
  - frame_done pulses once, then busy=0
- Both channels loaded, 3 frames each:
  - grants go 0,1,0,1,0,1
  - each output FIFO receives exactly 300 words, in order and uncorrupted
- in0 goes empty after 40 values for 20 cycles:
  - in0_rd_en stays 0 while empty and grant stays 0
  - the frame resumes and completes with in_cnt reaching 100
- out0_full held high for 10 cycles during DRAIN:
  - sm_full=1 and out0_wr_en=0
  - out_cnt frozen, then 100 results total
- Stub asserts sm_wr_en in IDLE:
  - err=1 and sticky; no output FIFO is written
- Reset asserted after 50 inputs of channel 1:
  - next cycle: busy=0, sm_empty=1, counters 0, grant=0
  - a new frame then starts cleanly on channel 0

Source files
------------

// File: rtl/softmax_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_arb_pkg
//  Description : Shared types, channel indices and width helper for the
//                two-channel softmax frame arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package softmax_arb_pkg;

  // Arbiter frame states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // Channel indices as carried on the grant signal
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Ceiling log2, used to size the frame counters
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : softmax_arb_pkg
`default_nettype wire

// File: rtl/softmax_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way round-robin selector. When both
//                requests are active the channel other than last_i wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
  import softmax_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       valid_o
);

  // Pick the requester, alternating on contention
  always_comb begin
    valid_o = |req_i;
    gnt_o   = CH0;
    if (&req_i) begin
      gnt_o = ~last_i;
    end else if (req_i[1]) begin
      gnt_o = CH1;
    end
  end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/softmax_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_arbiter
//  Description : Frame-granular round-robin arbiter sharing one softmax
//                datapath between two channels. A channel owns the softmax
//                from the first input read until its last result is written.
//  Revision    : 1.0 - initial release
// ============================================================================
module softmax_arbiter
  import softmax_arb_pkg::*;
#(
  parameter int DWIDTH_IN  = 16,
  parameter int DWIDTH_OUT = 16,
  parameter int VEC_LEN    = 100,
  parameter int CNT_W      = clog2(VEC_LEN + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  // channel input FIFOs (first-word-fall-through)
  output logic                  in0_rd_en,
  input  logic [DWIDTH_IN-1:0]  in0_dout,
  input  logic                  in0_empty,
  output logic                  in1_rd_en,
  input  logic [DWIDTH_IN-1:0]  in1_dout,
  input  logic                  in1_empty,
  // softmax read side
  input  logic                  sm_rd_en,
  output logic [DWIDTH_IN-1:0]  sm_dout,
  output logic                  sm_empty,
  // softmax write side
  input  logic                  sm_wr_en,
  input  logic [DWIDTH_OUT-1:0] sm_din,
  output logic                  sm_full,
  // channel output FIFOs
  output logic                  out0_wr_en,
  output logic [DWIDTH_OUT-1:0] out0_din,
  input  logic                  out0_full,
  output logic                  out1_wr_en,
  output logic [DWIDTH_OUT-1:0] out1_din,
  input  logic                  out1_full,
  // status
  output logic                  grant,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VEC_LEN);

  arb_state_e       state_q;
  logic             grant_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] in_cnt_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             frame_done_q;
  logic             err_q;

  logic             w_pick_gnt;
  logic             w_pick_valid;
  logic             w_sel_in_empty;
  logic [DWIDTH_IN-1:0] w_sel_in_dout;
  logic             w_sel_out_full;
  logic             w_out_room;
  logic             w_rd_acc;
  logic             w_wr_acc;

  rr_pick2 u_pick (
    .req_i   ({~in1_empty, ~in0_empty}),
    .last_i  (last_grant_q),
    .gnt_o   (w_pick_gnt),
    .valid_o (w_pick_valid)
  );

  // Steer the granted channel's FIFOs onto the softmax ports
  always_comb begin
    w_sel_in_empty = (grant_q == CH1) ? in1_empty : in0_empty;
    w_sel_in_dout  = (grant_q == CH1) ? in1_dout  : in0_dout;
    w_sel_out_full = (grant_q == CH1) ? out1_full : out0_full;
    // once a frame's results are complete further writes are refused
    w_out_room     = (out_cnt_q != CNT_FULL);

    in0_rd_en  = 1'b0;
    in1_rd_en  = 1'b0;
    sm_dout    = '0;
    sm_empty   = 1'b1;
    sm_full    = 1'b1;
    out0_wr_en = 1'b0;
    out1_wr_en = 1'b0;
    out0_din   = '0;
    out1_din   = '0;

    if (state_q == ST_FEED) begin
      sm_empty = w_sel_in_empty;
      sm_dout  = w_sel_in_dout;
      if (grant_q == CH1) begin
        in1_rd_en = sm_rd_en & ~in1_empty;
      end else begin
        in0_rd_en = sm_rd_en & ~in0_empty;
      end
    end

    // results may arrive while the frame is still being fed
    if (state_q != ST_IDLE) begin
      sm_full = w_sel_out_full | ~w_out_room;
      if (grant_q == CH1) begin
        out1_din   = sm_din;
        out1_wr_en = sm_wr_en & ~out1_full & w_out_room;
      end else begin
        out0_din   = sm_din;
        out0_wr_en = sm_wr_en & ~out0_full & w_out_room;
      end
    end

    w_rd_acc = in0_rd_en | in1_rd_en;
    w_wr_acc = out0_wr_en | out1_wr_en;
  end

  // Frame FSM: grant on idle, count reads and writes, release after last write
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= CH0;
      last_grant_q <= CH1;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      // a write with no owning frame, or beyond the frame length, is dropped
      if (sm_wr_en && ((state_q == ST_IDLE) || (out_cnt_q == CNT_FULL))) begin
        err_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (w_pick_valid) begin
            grant_q <= w_pick_gnt;
            state_q <= ST_FEED;
          end
        end

        ST_FEED, ST_DRAIN: begin
          if (w_rd_acc) begin
            in_cnt_q <= in_cnt_q + CNT_ONE;
            if (in_cnt_q == CNT_LAST) begin
              state_q <= ST_DRAIN;
            end
          end
          if (w_wr_acc) begin
            out_cnt_q <= out_cnt_q + CNT_ONE;
            if (out_cnt_q == CNT_LAST) begin
              frame_done_q <= 1'b1;
              last_grant_q <= grant_q;
              in_cnt_q     <= '0;
              out_cnt_q    <= '0;
              state_q      <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule : softmax_arbiter
`default_nettype wire

// File: tb/tb_softmax_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_softmax_arbiter
//  Description : Directed self-checking bench for softmax_arbiter with FIFO
//                models, a softmax stub and per-channel result scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_arbiter;

  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in0_rd_en, in1_rd_en;
  logic [DW-1:0] in0_dout = '0, in1_dout = '0;
  logic          in0_empty = 1'b1, in1_empty = 1'b1;
  logic          sm_rd_en = 1'b0;
  logic [DW-1:0] sm_dout;
  logic          sm_empty;
  logic          sm_wr_en = 1'b0;
  logic [DW-1:0] sm_din = '0;
  logic          sm_full;
  logic          out0_wr_en, out1_wr_en;
  logic [DW-1:0] out0_din, out1_din;
  logic          out0_full = 1'b0, out1_full = 1'b0;
  logic          grant, busy, frame_done, err;

  softmax_arbiter #(
    .DWIDTH_IN  (DW),
    .DWIDTH_OUT (DW),
    .VEC_LEN    (100)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in0_rd_en  (in0_rd_en),
    .in0_dout   (in0_dout),
    .in0_empty  (in0_empty),
    .in1_rd_en  (in1_rd_en),
    .in1_dout   (in1_dout),
    .in1_empty  (in1_empty),
    .sm_rd_en   (sm_rd_en),
    .sm_dout    (sm_dout),
    .sm_empty   (sm_empty),
    .sm_wr_en   (sm_wr_en),
    .sm_din     (sm_din),
    .sm_full    (sm_full),
    .out0_wr_en (out0_wr_en),
    .out0_din   (out0_din),
    .out0_full  (out0_full),
    .out1_wr_en (out1_wr_en),
    .out1_din   (out1_din),
    .out1_full  (out1_full),
    .grant      (grant),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clock = ~clock;

  // channel FIFO contents, softmax stub backlog, expected results
  logic [DW-1:0] q0[$], q1[$], pend[$], exp0[$], exp1[$];
  bit            glog[$];
  bit            stub_rd = 1'b1, stub_wr = 1'b1, force_wr = 1'b0;
  bit            full0 = 1'b0, full1 = 1'b0;
  bit            prev_busy = 1'b0;
  int            rd0_cnt, rd1_cnt, wr0_cnt, wr1_cnt, fd_cnt;
  int            n_chk = 0, n_pass = 0;

  function automatic logic [DW-1:0] sm_model(input logic [DW-1:0] x);
    logic [DW-1:0] t;
    t = x * 16'd3;
    return t + 16'h1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    in0_empty = (q0.size() == 0);
    in0_dout  = (q0.size() != 0) ? q0[0] : '0;
    in1_empty = (q1.size() == 0);
    in1_dout  = (q1.size() != 0) ? q1[0] : '0;
    sm_rd_en  = stub_rd;
    sm_wr_en  = force_wr || (stub_wr && (pend.size() != 0));
    sm_din    = (pend.size() != 0) ? sm_model(pend[0]) : '0;
    out0_full = full0;
    out1_full = full1;
  endtask

  task automatic load(input int ch, input int n);
    logic [DW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = DW'($urandom);
      if (ch == 0) begin q0.push_back(v); exp0.push_back(sm_model(v)); end
      else         begin q1.push_back(v); exp1.push_back(sm_model(v)); end
    end
    drive();
  endtask

  task automatic clear_counts();
    rd0_cnt = 0; rd1_cnt = 0; wr0_cnt = 0; wr1_cnt = 0; fd_cnt = 0;
    glog.delete();
  endtask

  // one clock: observe handshakes at negedge, commit them after posedge
  task automatic step();
    bit rd0, rd1, smrd, smwr, w0, w1;
    logic [DW-1:0] smd;
    @(negedge clock);
    rd0  = in0_rd_en;
    rd1  = in1_rd_en;
    smrd = sm_rd_en && !sm_empty;
    smd  = sm_dout;
    smwr = sm_wr_en && !sm_full;
    w0   = out0_wr_en;
    w1   = out1_wr_en;
    if (rd0) begin
      chk("in0_rd_nonempty", q0.size() != 0, 1);
      if (q0.size() != 0) chk("sm_dout_ch0", sm_dout, q0[0]);
    end
    if (rd1) begin
      chk("in1_rd_nonempty", q1.size() != 0, 1);
      if (q1.size() != 0) chk("sm_dout_ch1", sm_dout, q1[0]);
    end
    if (smrd || rd0 || rd1) chk("rd_handshake", smrd, rd0 | rd1);
    if (w0) begin
      chk("out0_not_full", out0_full, 0);
      chk("out0_expected", exp0.size() != 0, 1);
      if (exp0.size() != 0) chk("out0_data", out0_din, exp0[0]);
    end
    if (w1) begin
      chk("out1_not_full", out1_full, 0);
      chk("out1_expected", exp1.size() != 0, 1);
      if (exp1.size() != 0) chk("out1_data", out1_din, exp1[0]);
    end
    if (smwr || w0 || w1) chk("wr_handshake", smwr, w0 | w1);
    if (frame_done) begin
      fd_cnt++;
      chk("busy_at_done", busy, 0);
    end
    if (busy && !prev_busy) glog.push_back(grant);
    prev_busy = busy;

    @(posedge clock);
    #1;
    if (rd0 && q0.size() != 0) begin void'(q0.pop_front()); rd0_cnt++; end
    if (rd1 && q1.size() != 0) begin void'(q1.pop_front()); rd1_cnt++; end
    if (smrd) pend.push_back(smd);
    if (smwr && pend.size() != 0) void'(pend.pop_front());
    if (w0) begin wr0_cnt++; if (exp0.size() != 0) void'(exp0.pop_front()); end
    if (w1) begin wr1_cnt++; if (exp1.size() != 0) void'(exp1.pop_front()); end
    drive();
  endtask

  task automatic apply_reset();
    stub_rd = 1'b0;
    stub_wr = 1'b0;
    reset   = 1'b1;
    drive();
    step();
    reset = 1'b0;
    q0.delete(); q1.delete(); pend.delete(); exp0.delete(); exp1.delete();
    stub_rd = 1'b1;
    stub_wr = 1'b1;
    drive();
  endtask

  task automatic wait_fd(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (fd_cnt < n && c < budget) begin step(); c++; end
    chk(tag, fd_cnt >= n, 1);
  endtask

  task automatic wait_rd(input int ch, input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (((ch == 0) ? rd0_cnt : rd1_cnt) < n && c < budget) begin step(); c++; end
    chk(tag, ((ch == 0) ? rd0_cnt : rd1_cnt) >= n, 1);
  endtask

  initial begin
    // ---- reset state
    apply_reset();
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    chk("rst_grant", grant, 0);
    chk("rst_sm_empty", sm_empty, 1);
    chk("rst_sm_full", sm_full, 1);
    chk("rst_strobes", {in0_rd_en, in1_rd_en, out0_wr_en, out1_wr_en}, 4'b0000);

    // ---- single channel frame
    clear_counts();
    load(0, 100);
    wait_fd(1, 1000, "t1_timeout");
    repeat (3) step();
    chk("t1_frames", fd_cnt, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_out0_words", wr0_cnt, 100);
    chk("t1_out1_words", wr1_cnt, 0);
    chk("t1_grants", glog.size(), 1);
    if (glog.size() != 0) chk("t1_grant0", glog[0], 0);

    // ---- both channels, three frames each, alternating grants
    apply_reset();
    clear_counts();
    load(0, 300);
    load(1, 300);
    wait_fd(6, 5000, "t2_timeout");
    repeat (2) step();
    chk("t2_grants", glog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < glog.size()) chk($sformatf("t2_grant%0d", i), glog[i], i % 2);
    end
    chk("t2_out0_words", wr0_cnt, 300);
    chk("t2_out1_words", wr1_cnt, 300);
    chk("t2_exp_left", exp0.size() + exp1.size(), 0);

    // ---- input runs dry mid-frame
    clear_counts();
    load(0, 40);
    wait_rd(0, 40, 500, "t3_first40");
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t3_hold_rd", in0_rd_en, 0);
      chk("t3_hold_grant", grant, 0);
      chk("t3_hold_busy", busy, 1);
    end
    chk("t3_in_cnt_hold", dut.in_cnt_q, 40);
    load(0, 60);
    wait_fd(1, 1000, "t3_timeout");
    chk("t3_reads", rd0_cnt, 100);
    chk("t3_out0_words", wr0_cnt, 100);

    // ---- output backpressure during drain
    repeat (2) step();
    clear_counts();
    stub_wr = 1'b0;
    load(0, 100);
    wait_rd(0, 100, 500, "t4_feed");
    repeat (2) step();
    chk("t4_drain_empty", sm_empty, 1);
    chk("t4_drain_busy", busy, 1);
    full0   = 1'b1;
    stub_wr = 1'b1;
    drive();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_sm_full", sm_full, 1);
      chk("t4_out0_wr", out0_wr_en, 0);
    end
    chk("t4_frozen_words", wr0_cnt, 0);
    chk("t4_frozen_cnt", dut.out_cnt_q, 0);
    full0 = 1'b0;
    drive();
    wait_fd(1, 1000, "t4_timeout");
    chk("t4_out0_words", wr0_cnt, 100);
    chk("t4_err_clean", err, 0);

    // ---- stray softmax write while idle
    repeat (2) step();
    clear_counts();
    chk("t5_idle", busy, 0);
    force_wr = 1'b1;
    drive();
    step();
    force_wr = 1'b0;
    drive();
    step();
    chk("t5_err_set", err, 1);
    repeat (5) step();
    chk("t5_err_sticky", err, 1);
    chk("t5_no_writes", wr0_cnt + wr1_cnt, 0);
    chk("t5_still_idle", busy, 0);

    // ---- reset mid-frame on channel 1
    clear_counts();
    load(1, 100);
    wait_rd(1, 50, 500, "t6_first50");
    apply_reset();
    chk("t6_busy", busy, 0);
    chk("t6_sm_empty", sm_empty, 1);
    chk("t6_grant", grant, 0);
    chk("t6_err", err, 0);
    chk("t6_in_cnt", dut.in_cnt_q, 0);
    chk("t6_out_cnt", dut.out_cnt_q, 0);
    clear_counts();
    load(0, 100);
    load(1, 100);
    wait_fd(2, 2000, "t6_timeout");
    chk("t6_grants", glog.size(), 2);
    if (glog.size() > 0) chk("t6_first_grant", glog[0], 0);
    if (glog.size() > 1) chk("t6_second_grant", glog[1], 1);
    chk("t6_out0_words", wr0_cnt, 100);
    chk("t6_out1_words", wr1_cnt, 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_softmax_arbiter
`default_nettype wire
